// File: rtl/sopc_system_mul_cell_arbiter.sv
// Round-robin arbiter sharing one pipelined 32x32 multiplier cell.
// A shadow {valid,id} pipeline tracks each product back to its issuer.
module sopc_system_mul_cell_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int MUL_LATENCY = 2,
   localparam int CW         = $clog2(MUL_LATENCY + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pipe_hold,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [32*NUM_REQ-1:0]   req_src1,
   input  logic [32*NUM_REQ-1:0]   req_src2,
   input  logic [NUM_REQ-1:0]      req_src1_signed,
   input  logic [NUM_REQ-1:0]      req_src2_signed,
   output logic [31:0]             mul_src1,
   output logic [31:0]             mul_src2,
   output logic                    mul_src1_signed,
   output logic                    mul_src2_signed,
   output logic                    mul_en_in,
   output logic                    mul_en_out,
   input  logic [63:0]             mul_result,
   output logic                    rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [63:0]             rsp_result,
   output logic [CW-1:0]           in_flight,
   output logic                    idle
);

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   in_flight_q, in_flight_d;
   logic [MUL_LATENCY-1:0] vld_q, vld_d;
   logic [ID_W-1:0] id_q [MUL_LATENCY];
   logic [ID_W-1:0] id_d [MUL_LATENCY];

   logic            found;
   logic            grant_any;
   logic [ID_W-1:0] grant_id;
   logic [ID_W-1:0] sel;
   logic            deliver;

   logic [31:0] src1_a [NUM_REQ];
   logic [31:0] src2_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign src1_a[g] = req_src1[32*g +: 32];
      assign src2_a[g] = req_src2[32*g +: 32];
   end

   // Search starting at rr_ptr, wrapping; first valid wins
   always_comb begin
      found    = 1'b0;
      grant_id = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found    = 1'b1;
            grant_id = idx[ID_W-1:0];
         end
      end
      grant_any = found & ~pipe_hold & ~reset;
      req_ready = '0;
      if (grant_any) req_ready[grant_id] = 1'b1;
   end

   assign sel             = grant_any ? grant_id : rr_ptr_q;
   assign mul_src1        = src1_a[sel];
   assign mul_src2        = src2_a[sel];
   assign mul_src1_signed = req_src1_signed[sel];
   assign mul_src2_signed = req_src2_signed[sel];
   assign mul_en_in       = ~pipe_hold;
   assign mul_en_out      = ~pipe_hold;

   assign deliver    = vld_q[MUL_LATENCY-1] & ~pipe_hold & ~reset;
   assign rsp_valid  = deliver;
   assign rsp_id     = id_q[MUL_LATENCY-1];
   assign rsp_result = mul_result;
   assign in_flight  = in_flight_q;
   assign idle       = ~|req_valid & (in_flight_q == '0);

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         if (int'(grant_id) == NUM_REQ - 1) rr_ptr_d = '0;
         else rr_ptr_d = grant_id + 1'b1;
      end
   end

   always_comb begin
      vld_d = vld_q;
      id_d  = id_q;
      if (!pipe_hold) begin
         vld_d[0] = grant_any;
         id_d[0]  = grant_id;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
         end
      end
   end

   always_comb begin
      in_flight_d = in_flight_q;
      if (grant_any && !deliver) in_flight_d = in_flight_q + 1'b1;
      else if (!grant_any && deliver) in_flight_d = in_flight_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q    <= '0;
         in_flight_q <= '0;
         vld_q       <= '0;
         for (int i = 0; i < MUL_LATENCY; i++) id_q[i] <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         in_flight_q <= in_flight_d;
         vld_q       <= vld_d;
         id_q        <= id_d;
      end
   end

endmodule

// File: tb/tb_sopc_system_mul_cell_arbiter.sv
// Directed bench for the multiplier cell arbiter.
// Includes a two-stage behavioural model of the multiplier cell.
module tb_sopc_system_mul_cell_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         pipe_hold;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_src1;
   logic [127:0] req_src2;
   logic [3:0]   req_src1_signed;
   logic [3:0]   req_src2_signed;
   logic [31:0]  mul_src1;
   logic [31:0]  mul_src2;
   logic         mul_src1_signed;
   logic         mul_src2_signed;
   logic         mul_en_in;
   logic         mul_en_out;
   logic [63:0]  mul_result;
   logic         rsp_valid;
   logic [1:0]   rsp_id;
   logic [63:0]  rsp_result;
   logic [1:0]   in_flight;
   logic         idle;

   int total = 0;
   int bad   = 0;

   sopc_system_mul_cell_arbiter dut (
      .clk             (clk),
      .reset           (reset),
      .pipe_hold       (pipe_hold),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_src1        (req_src1),
      .req_src2        (req_src2),
      .req_src1_signed (req_src1_signed),
      .req_src2_signed (req_src2_signed),
      .mul_src1        (mul_src1),
      .mul_src2        (mul_src2),
      .mul_src1_signed (mul_src1_signed),
      .mul_src2_signed (mul_src2_signed),
      .mul_en_in       (mul_en_in),
      .mul_en_out      (mul_en_out),
      .mul_result      (mul_result),
      .rsp_valid       (rsp_valid),
      .rsp_id          (rsp_id),
      .rsp_result      (rsp_result),
      .in_flight       (in_flight),
      .idle            (idle)
   );

   always #5 clk = ~clk;

   // Multiplier cell: input register then output register
   logic [31:0] a_q = '0;
   logic [31:0] b_q = '0;
   logic        sa_q = 1'b0;
   logic        sb_q = 1'b0;
   logic [63:0] p_q = '0;
   logic [63:0] ax, bx;
   assign ax = {{32{sa_q & a_q[31]}}, a_q};
   assign bx = {{32{sb_q & b_q[31]}}, b_q};
   always @(posedge clk) begin
      if (mul_en_in) begin
         a_q  <= mul_src1;
         b_q  <= mul_src2;
         sa_q <= mul_src1_signed;
         sb_q <= mul_src2_signed;
      end
      if (mul_en_out) p_q <= ax * bx;
   end
   assign mul_result = p_q;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic sb);
      req_src1[32*i +: 32] = a;
      req_src2[32*i +: 32] = b;
      req_src1_signed[i]   = sa;
      req_src2_signed[i]   = sb;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      pipe_hold = 1'b0;
      req_valid = 4'b1111;
      req_src1 = '0;
      req_src2 = '0;
      req_src1_signed = '0;
      req_src2_signed = '0;
      #1;
      total++;
      if (req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL reset_ready got=%b exp=0000", req_ready);
      end
      tick();
      tick();
      req_valid = 4'b0000;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || in_flight !== 2'd0 || rsp_id !== 2'd0) begin
         bad++;
         $display("FAIL reset_state got=%b/%0d/%0d exp=0/0/0", rsp_valid, in_flight, rsp_id);
      end
      reset = 1'b0;
      #1;
      total++;
      if (idle !== 1'b1) begin
         bad++;
         $display("FAIL reset_idle got=%b exp=1", idle);
      end
   endtask

   task automatic test_single;
      set_op(2, 32'd7, 32'd6, 1'b0, 1'b0);
      req_valid = 4'b0100;
      #1;
      total++;
      if (req_ready !== 4'b0100) begin
         bad++;
         $display("FAIL single_ready got=%b exp=0100", req_ready);
      end
      tick();
      req_valid = 4'b0000;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || in_flight !== 2'd1 || req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL single_mid got=%b/%0d/%b exp=0/1/0000", rsp_valid, in_flight, req_ready);
      end
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 64'd42) begin
         bad++;
         $display("FAIL single_rsp got=%b/%0d/%h exp=1/2/2a", rsp_valid, rsp_id, rsp_result);
      end
      tick();
      total++;
      if (rsp_valid !== 1'b0 || in_flight !== 2'd0 || idle !== 1'b1) begin
         bad++;
         $display("FAIL single_drain got=%b/%0d/%b exp=0/0/1", rsp_valid, in_flight, idle);
      end
   endtask

   task automatic test_signed;
      logic [63:0] exp_r [2];
      exp_r[0] = 64'hFFFFFFFFFFFFFFFD;
      exp_r[1] = 64'h00000002FFFFFFFD;
      for (int s = 0; s < 2; s++) begin
         set_op(0, 32'hFFFFFFFF, 32'd3, (s == 0), (s == 0));
         req_valid = 4'b0001;
         #1;
         total++;
         if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL signed_ready%0d got=%b exp=0001", s, req_ready);
         end
         tick();
         req_valid = 4'b0000;
         tick();
         total++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== exp_r[s]) begin
            bad++;
            $display("FAIL signed_rsp%0d got=%b/%0d/%h exp=1/0/%h",
                     s, rsp_valid, rsp_id, rsp_result, exp_r[s]);
         end
         tick();
      end
   endtask

   task automatic test_round_robin;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_op(i, i + 1, 32'd10, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         logic [3:0] exp_rdy;
         int eid;
         req_valid = (k < 8) ? 4'b1111 : 4'b0000;
         exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
         #1;
         total++;
         if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL rr_ready%0d got=%b exp=%b", k, req_ready, exp_rdy);
         end
         if (k >= 2) begin
            eid = (k - 2) % 4;
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(eid) || rsp_result !== 64'((eid + 1) * 10)) begin
               bad++;
               $display("FAIL rr_rsp%0d got=%b/%0d/%0d exp=1/%0d/%0d",
                        k, rsp_valid, rsp_id, rsp_result, eid, (eid + 1) * 10);
            end
         end
         if (k >= 2 && k < 8) begin
            total++;
            if (in_flight !== 2'd2) begin
               bad++;
               $display("FAIL rr_inflight%0d got=%0d exp=2", k, in_flight);
            end
         end
         tick();
      end
   endtask

   task automatic test_hold;
      set_op(1, 32'd5, 32'd5, 1'b0, 1'b0);
      req_valid = 4'b0010;
      #1;
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL hold_grant got=%b exp=0010", req_ready);
      end
      tick();
      for (int j = 0; j < 3; j++) begin
         pipe_hold = 1'b1;
         req_valid = 4'b1000;
         #1;
         total++;
         if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || mul_en_in !== 1'b0) begin
            bad++;
            $display("FAIL hold_cycle%0d got=%b/%b/%b exp=0000/0/0", j, req_ready, rsp_valid, mul_en_in);
         end
         tick();
      end
      pipe_hold = 1'b0;
      req_valid = 4'b0000;
      #1;
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_early got=%b exp=0", rsp_valid);
      end
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 64'd25) begin
         bad++;
         $display("FAIL hold_rsp got=%b/%0d/%0d exp=1/1/25", rsp_valid, rsp_id, rsp_result);
      end
      tick();
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_once got=%b exp=0", rsp_valid);
      end
   endtask

   task automatic test_hold_response;
      set_op(3, 32'd9, 32'd9, 1'b0, 1'b0);
      req_valid = 4'b1000;
      #1;
      total++;
      if (req_ready !== 4'b1000) begin
         bad++;
         $display("FAIL hrsp_grant got=%b exp=1000", req_ready);
      end
      tick();
      req_valid = 4'b0000;
      tick();
      for (int j = 0; j < 2; j++) begin
         pipe_hold = 1'b1;
         #1;
         total++;
         if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL hrsp_held%0d got=%b exp=0", j, rsp_valid);
         end
         tick();
      end
      pipe_hold = 1'b0;
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 64'd81) begin
         bad++;
         $display("FAIL hrsp_rsp got=%b/%0d/%0d exp=1/3/81", rsp_valid, rsp_id, rsp_result);
      end
      tick();
      total++;
      if (rsp_valid !== 1'b0 || in_flight !== 2'd0) begin
         bad++;
         $display("FAIL hrsp_once got=%b/%0d exp=0/0", rsp_valid, in_flight);
      end
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 5; k++) begin
         req_valid = (k < 3) ? 4'b0100 : 4'b0000;
         set_op(2, k + 2, k + 3, 1'b0, 1'b0);
         #1;
         total++;
         if (req_ready !== ((k < 3) ? 4'b0100 : 4'b0000)) begin
            bad++;
            $display("FAIL b2b_ready%0d got=%b", k, req_ready);
         end
         if (k >= 2) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 64'(k * (k + 1))) begin
               bad++;
               $display("FAIL b2b_rsp%0d got=%b/%0d/%0d exp=1/2/%0d",
                        k, rsp_valid, rsp_id, rsp_result, k * (k + 1));
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid;
      set_op(0, 32'd3, 32'd3, 1'b0, 1'b0);
      set_op(1, 32'd4, 32'd4, 1'b0, 1'b0);
      req_valid = 4'b0011;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL rmid_g0 got=%b exp=0001", req_ready);
      end
      tick();
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL rmid_g1 got=%b exp=0010", req_ready);
      end
      tick();
      reset = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL rmid_during got=%b/%b exp=0000/0", req_ready, rsp_valid);
      end
      tick();
      reset = 1'b0;
      req_valid = 4'b0000;
      #1;
      total++;
      if (in_flight !== 2'd0 || idle !== 1'b1 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL rmid_after got=%0d/%b/%b exp=0/1/0", in_flight, idle, rsp_valid);
      end
      for (int j = 0; j < 2; j++) begin
         tick();
         total++;
         if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmid_norsp%0d got=%b exp=0", j, rsp_valid);
         end
      end
      req_valid = 4'b1010;
      #1;
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL rmid_next got=%b exp=0010", req_ready);
      end
      tick();
      req_valid = 4'b0000;
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 64'd16) begin
         bad++;
         $display("FAIL rmid_rsp got=%b/%0d/%0d exp=1/1/16", rsp_valid, rsp_id, rsp_result);
      end
      tick();
   endtask

   task automatic test_starvation;
      logic [3:0] exp_rdy [6];
      int seen3;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_op(0, 32'd1, 32'd1, 1'b0, 1'b0);
      set_op(3, 32'd2, 32'd2, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) exp_rdy[k] = (k % 2 == 0) ? 4'b0001 : 4'b1000;
      seen3 = -1;
      for (int k = 0; k < 6; k++) begin
         req_valid = (k % 2 == 0) ? 4'b1001 : 4'b1000;
         #1;
         if (req_ready[3] === 1'b1 && seen3 < 0) seen3 = k;
         total++;
         if (req_ready !== exp_rdy[k]) begin
            bad++;
            $display("FAIL starve_ready%0d got=%b exp=%b", k, req_ready, exp_rdy[k]);
         end
         tick();
      end
      total++;
      if (seen3 < 0 || seen3 >= 4) begin
         bad++;
         $display("FAIL starve_bound got=%0d exp=<4", seen3);
      end
      req_valid = 4'b0000;
      tick();
      tick();
      tick();
      total++;
      if (idle !== 1'b1 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL starve_idle got=%b/%b exp=1/0", idle, rsp_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_signed();
      test_round_robin();
      test_hold();
      test_hold_response();
      test_back_to_back();
      test_reset_mid();
      test_starvation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
